// File: rtl/md_pkg.sv
// md_pkg: shared op/state encodings and default latencies for the multiply/divide sequencer
package md_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_RUN} md_state_e;
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  function automatic logic md_is_div(input logic [2:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
  function automatic logic md_is_mt(input logic [2:0] op);
    return op == MD_MTHI || op == MD_MTLO;
  endfunction
  function automatic logic md_valid(input logic [2:0] op);
    return op <= MD_MTLO;
  endfunction
endpackage

// File: rtl/muldiv_arith.sv
// muldiv_arith: combinational 64-bit mult/div result ({hi,lo}) and divide-by-zero flag
module muldiv_arith
  import md_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [63:0] o_res,
  output logic        o_dz
);
  logic        w_sgn, w_an, w_bn;
  logic [31:0] w_ma, w_mb, w_den, w_q, w_r;
  logic [63:0] w_prod;
  // Division runs on magnitudes so the INT_MIN / -1 case wraps to 0x80000000 instead of trapping
  always_comb begin
    w_sgn  = (i_op == MD_MULT) || (i_op == MD_DIV);
    w_prod = {{32{w_sgn & i_rs[31]}}, i_rs} * {{32{w_sgn & i_rt[31]}}, i_rt};
    w_an   = w_sgn & i_rs[31];
    w_bn   = w_sgn & i_rt[31];
    w_ma   = w_an ? -i_rs : i_rs;
    w_mb   = w_bn ? -i_rt : i_rt;
    w_den  = (w_mb == '0) ? 32'd1 : w_mb;
    w_q    = w_ma / w_den;
    w_r    = w_ma % w_den;
    o_dz   = md_is_div(i_op) && (i_rt == '0);
    o_res  = md_is_div(i_op) ? {w_an ? -w_r : w_r, (w_an ^ w_bn) ? -w_q : w_q} : w_prod;
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: HI/LO owner; holds md results in shadow until the issuing instruction is past the flush point
module muldiv_seq
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  md_state_e   r_state, w_next;
  logic [2:0]  r_op;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_sh_hi, r_sh_lo, r_hi, r_lo;
  logic        r_dz;
  logic [63:0] w_res;
  logic        w_dz, w_take, w_mt_commit, w_run_end;
  muldiv_arith u_arith (
    .i_op (md_op),
    .i_rs (rs_val),
    .i_rt (rt_val),
    .o_res(w_res),
    .o_dz (w_dz)
  );
  always_comb begin
    w_take      = start && !flush && md_valid(md_op);
    w_mt_commit = (r_state == S_PEND) && !flush && md_is_mt(r_op);
    w_run_end   = (r_state == S_RUN) && (r_cnt == '0);
    w_next      = (r_state == S_IDLE) ? (w_take ? S_PEND : S_IDLE) :
                  (r_state == S_PEND) ? ((flush || md_is_mt(r_op)) ? S_IDLE : S_RUN) :
                  (w_run_end ? S_IDLE : S_RUN);
    busy        = r_state != S_IDLE;
    done        = w_mt_commit || w_run_end;
    hi          = r_hi;
    lo          = r_lo;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_sh_hi <= '0;
      r_sh_lo <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_take) begin
        r_op    <= md_op;
        r_dz    <= w_dz;
        r_sh_hi <= (md_op == MD_MTHI) ? rs_val : (md_op == MD_MTLO) ? r_hi : w_res[63:32];
        r_sh_lo <= (md_op == MD_MTLO) ? rs_val : (md_op == MD_MTHI) ? r_lo : w_res[31:0];
      end
      // Counter is loaded once the op leaves the flush window; N-2 accounts for the PEND cycle and the final cycle
      if (r_state == S_PEND && !flush && !md_is_mt(r_op))
        r_cnt <= md_is_div(r_op) ? CW'(DIV_CYCLES - 2) : CW'(MULT_CYCLES - 2);
      else if (r_state == S_RUN && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
      if (w_mt_commit || (w_run_end && !r_dz)) begin
        r_hi <= r_sh_hi;
        r_lo <= r_sh_lo;
      end
    end
  end
endmodule
